// File: rtl/toast_hazard_ctrl.sv
// ============================================================================
//  Module   : toast_hazard_ctrl
//  Brief    : Forwarding selects plus sequenced load-use / dmem-wait / flush
//             hazard FSM for the Toast RV32I pipeline. Optional perf counters
//             are enabled by defining TOAST_HAZARD_PERF_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module toast_hazard_ctrl #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int LOAD_STALL_CYCLES  = 1,
    parameter int FLUSH_CYCLES       = 2
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rs1_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rs2_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rd_addr_i,
    input  logic [1:0]                    ID_alu_source_sel_i,
    input  logic                          ID_mem_rd_en_i,
    input  logic                          ID_jump_en_i,
    input  logic [31:0]                   IF_instruction_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_rd_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_rs2_addr_i,
    input  logic                          EX_rd_wr_en_i,
    input  logic                          EX_branch_en_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] MEM_rd_addr_i,
    input  logic                          MEM_rd_wr_en_i,
    input  logic                          MEM_mem_req_i,
    input  logic                          dmem_ready_i,
    output logic [1:0]                    forwardA_o,
    output logic [1:0]                    forwardB_o,
    output logic                          forwardM_o,
    output logic                          stall_o,
    output logic                          IF_ID_flush_o,
    output logic                          EX_flush_o,
    output logic [1:0]                    state_o,
    output logic [31:0]                   stall_cycles_o,
    output logic [31:0]                   flush_events_o
);

    localparam logic [1:0] S_IDLE       = 2'b00;
    localparam logic [1:0] S_LOAD_STALL = 2'b01;
    localparam logic [1:0] S_MEM_WAIT   = 2'b10;
    localparam logic [1:0] S_FLUSH      = 2'b11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_load_stall
        $error("LOAD_STALL_CYCLES must be 1..7");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush
        $error("FLUSH_CYCLES must be 1..3");
    end

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [REGFILE_ADDR_WIDTH-1:0] w_if_rs1, w_if_rs2;
    logic                          w_uses_rs1, w_uses_rs2, w_ld_haz;
    logic                          w_mem_wait, w_flush_req;
    logic                          w_ex_a, w_ex_b, w_mem_a, w_mem_b;
    logic [1:0]                    w_fwd_a, w_fwd_b;
    logic                          w_stall, w_flush, w_ex_flush, w_flush_acc;
    logic                          w_unused_bits;

    assign w_if_rs1      = REGFILE_ADDR_WIDTH'(IF_instruction_i[19:15]);
    assign w_if_rs2      = REGFILE_ADDR_WIDTH'(IF_instruction_i[24:20]);
    assign w_unused_bits = ^{IF_instruction_i[31:25], IF_instruction_i[14:7]};

    always_comb begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (IF_instruction_i[6:0])
            OPC_OP, OPC_BRANCH, OPC_STORE: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign w_ld_haz = ID_mem_rd_en_i && (ID_rd_addr_i != '0) &&
                      ((w_uses_rs1 && (ID_rd_addr_i == w_if_rs1)) ||
                       (w_uses_rs2 && (ID_rd_addr_i == w_if_rs2)));

    assign w_mem_wait  = MEM_mem_req_i & ~dmem_ready_i;
    assign w_flush_req = EX_branch_en_i | ID_jump_en_i;

    assign w_ex_a  = EX_rd_wr_en_i  && (EX_rd_addr_i  != '0) && (EX_rd_addr_i  == ID_rs1_addr_i);
    assign w_ex_b  = EX_rd_wr_en_i  && (EX_rd_addr_i  != '0) && (EX_rd_addr_i  == ID_rs2_addr_i);
    assign w_mem_a = MEM_rd_wr_en_i && (MEM_rd_addr_i != '0) && (MEM_rd_addr_i == ID_rs1_addr_i);
    assign w_mem_b = MEM_rd_wr_en_i && (MEM_rd_addr_i != '0) && (MEM_rd_addr_i == ID_rs2_addr_i);

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (!ID_alu_source_sel_i[1]) begin
            if (w_ex_a)       w_fwd_a = 2'b10;
            else if (w_mem_a) w_fwd_a = 2'b01;
        end
        if (!ID_alu_source_sel_i[0]) begin
            if (w_ex_b)       w_fwd_b = 2'b10;
            else if (w_mem_b) w_fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counters freeze whenever a dmem wait is pending, whatever the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_mem_wait) begin
                    state_d = S_MEM_WAIT;
                end else if (w_flush_req) begin
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = FLUSH_RELOAD;
                        state_d = S_FLUSH;
                    end
                end else if (w_ld_haz) begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        cnt_d   = LOAD_RELOAD;
                        state_d = S_LOAD_STALL;
                    end
                end
            end
            S_LOAD_STALL: begin
                if (!w_mem_wait) begin
                    if (cnt_q == 3'd1) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
            S_MEM_WAIT: begin
                if (!w_mem_wait) state_d = S_IDLE;
            end
            default: begin
                if (!w_mem_wait) begin
                    if (w_flush_req)         cnt_d   = FLUSH_RELOAD;
                    else if (cnt_q == 3'd1)  state_d = S_IDLE;
                    else                     cnt_d   = cnt_q - 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        w_ex_flush  = 1'b0;
        w_flush_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_mem_wait) begin
                    w_stall = 1'b1;
                end else if (w_flush_req) begin
                    w_flush     = 1'b1;
                    w_ex_flush  = EX_branch_en_i;
                    w_flush_acc = 1'b1;
                end else if (w_ld_haz) begin
                    w_stall = 1'b1;
                end
            end
            S_LOAD_STALL: w_stall = 1'b1;
            S_MEM_WAIT:   w_stall = w_mem_wait;
            default: begin
                w_flush = 1'b1;
                if (w_mem_wait) begin
                    w_stall = 1'b1;
                end else if (w_flush_req) begin
                    w_ex_flush  = EX_branch_en_i;
                    w_flush_acc = 1'b1;
                end
            end
        endcase
    end

    // Combinational paths are masked so every output reads 0 during reset.
    assign forwardA_o    = resetn_i ? w_fwd_a : 2'b00;
    assign forwardB_o    = resetn_i ? w_fwd_b : 2'b00;
    assign forwardM_o    = resetn_i & MEM_rd_wr_en_i & (MEM_rd_addr_i != '0) &
                           (MEM_rd_addr_i == EX_rs2_addr_i);
    assign stall_o       = resetn_i & w_stall;
    assign IF_ID_flush_o = resetn_i & w_flush;
    assign EX_flush_o    = resetn_i & w_ex_flush;
    assign state_o       = state_q;

`ifdef TOAST_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (w_flush_acc && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`else
    logic w_unused_perf;
    assign w_unused_perf  = w_flush_acc;
    assign stall_cycles_o = 32'd0;
    assign flush_events_o = 32'd0;
`endif

endmodule

`default_nettype wire
